// File: rtl/sparse_conv_scatter.sv
// Valid-mode 2-D convolution of a sparse (value, col, row) stream: each entry is scattered
// through a preloaded KxK kernel into an accumulator map, then the map is drained in raster order.
//
// state   | meaning
// LOAD    | accepting K*K kernel weights
// RUN     | waiting for the next sparse entry
// SCATTER | K*K cycles of multiply-accumulate for the latched entry
// DRAIN   | streaming and clearing the M*M result map
module sparse_conv_scatter #(
    parameter int word_length = 8,
    parameter int col_length  = 8,
    parameter int acc_length  = 24,
    parameter int kernel_size = 5,
    parameter int image_size  = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    input  logic [word_length-1:0] w_data,
    output logic                   w_ready,
    input  logic                   in_valid,
    input  logic [word_length-1:0] in_value,
    input  logic [col_length-1:0]  in_col,
    input  logic [col_length-1:0]  in_row,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [acc_length-1:0]  out_data,
    output logic                   out_last,
    input  logic                   out_ready
);

    localparam int M  = image_size - kernel_size + 1;
    localparam int KK = kernel_size * kernel_size;
    localparam int MM = M * M;
    localparam int KW = $clog2(KK + 1);
    localparam int KB = $clog2(kernel_size);
    localparam int AW = $clog2(MM);
    localparam int PW = 2 * word_length;

    typedef enum logic [1:0] {LOAD, RUN, SCATTER, DRAIN} state_t;
    state_t state, state_nx;

    logic signed [word_length-1:0] w   [KK];
    logic signed [acc_length-1:0]  acc [MM];

    logic [KW-1:0]                 w_idx;
    logic [KB-1:0]                 ki, kj;
    logic [AW-1:0]                 rd_idx, rd_nx;
    logic signed [word_length-1:0] lat_value;
    logic [col_length-1:0]         lat_col, lat_row;
    logic                          lat_last;

    logic                          w_end, k_end, rd_last, hit;
    logic [KW-1:0]                 k_sel;
    logic [AW-1:0]                 tgt;
    logic signed [PW-1:0]          prod;
    logic signed [acc_length-1:0]  prod_ext;
    int                            tr, tc;

    always_comb begin
        tr       = int'(lat_row) - int'(ki);
        tc       = int'(lat_col) - int'(kj);
        hit      = (tr >= 0) && (tr < M) && (tc >= 0) && (tc < M);
        tgt      = AW'(tr * M + tc);
        k_sel    = KW'(int'(ki) * kernel_size + int'(kj));
        prod     = lat_value * w[k_sel];
        prod_ext = {{(acc_length - PW){prod[PW-1]}}, prod};
        w_end    = w_valid && (w_idx == KW'(KK - 1));
        k_end    = (ki == KB'(kernel_size - 1)) && (kj == KB'(kernel_size - 1));
        rd_last  = (rd_idx == AW'(MM - 1));
        rd_nx    = rd_idx + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (w_end) state_nx = RUN;
            RUN:     if (in_valid) state_nx = SCATTER;
            SCATTER: if (k_end) state_nx = lat_last ? DRAIN : RUN;
            DRAIN:   if (out_ready && rd_last) state_nx = RUN;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        w_ready   = (state == LOAD);
        in_ready  = (state == RUN);
        out_valid = (state == DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KK; i++) w[i] <= '0;
            for (int i = 0; i < MM; i++) acc[i] <= '0;
            w_idx     <= '0;
            ki        <= '0;
            kj        <= '0;
            rd_idx    <= '0;
            lat_value <= '0;
            lat_col   <= '0;
            lat_row   <= '0;
            lat_last  <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (w_valid) begin
                        w[w_idx] <= w_data;
                        w_idx    <= w_idx + KW'(1);
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        lat_value <= in_value;
                        lat_col   <= in_col;
                        lat_row   <= in_row;
                        lat_last  <= in_last;
                        ki        <= '0;
                        kj        <= '0;
                    end
                end
                SCATTER: begin
                    if (hit) acc[tgt] <= acc[tgt] + prod_ext;
                    if (kj == KB'(kernel_size - 1)) begin
                        kj <= '0;
                        ki <= ki + KB'(1);
                    end else begin
                        kj <= kj + KB'(1);
                    end
                    // First drain word is registered here, so fold in a final product landing on acc[0]
                    if (k_end && lat_last) begin
                        rd_idx   <= '0;
                        out_data <= (hit && tgt == '0) ? acc[0] + prod_ext : acc[0];
                        out_last <= (MM == 1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        acc[rd_idx] <= '0;
                        if (rd_last) begin
                            rd_idx   <= '0;
                            out_data <= '0;
                            out_last <= 1'b0;
                        end else begin
                            rd_idx   <= rd_nx;
                            out_data <= acc[rd_nx];
                            out_last <= (rd_nx == AW'(MM - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
